// File: rtl/aib_cfg_regfile_mc.sv
// AIB multi-channel configuration register file: APB-programmed shadow registers per
// channel, copied to the active outputs by a delayed, per-channel commit sequence.
module aib_cfg_regfile_mc #(
  parameter int         NUM_CHN = 4,
  parameter int         NUM_IO  = 96,
  parameter logic [7:0] CHG_DLY = 8'd255
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst_n,
  input  logic                                 i_psel,
  input  logic                                 i_penable,
  input  logic                                 i_pwrite,
  input  logic [15:0]                          i_paddr,
  input  logic [31:0]                          i_pwdata,
  output logic                                 o_pready,
  output logic                                 o_pslverr,
  output logic [31:0]                          o_prdata,
  input  logic [NUM_CHN-1:0][3:0]              i_evt,
  output logic [NUM_CHN-1:0][2:0]              o_chn_mode,
  output logic [NUM_CHN-1:0][11:0]             o_clkgen_cfg,
  output logic [NUM_CHN-1:0][NUM_IO-1:0][26:0] o_buf_cfg,
  output logic [NUM_CHN-1:0]                   o_cfg_chg,
  output logic                                 o_busy,
  output logic [1:0]                           o_dbg_state
);
  localparam logic [2:0]  MODE_RST = 3'b100;
  localparam logic [11:0] CLK_RST  = 12'hCFF;
  localparam logic [26:0] BUF_RST  = 27'h0B10000;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_COPY = 2'd1, S_WAIT = 2'd2, S_TOGGLE = 2'd3} state_t;

  logic [3:0] ch;
  logic [9:0] word;
  logic [7:0] io_idx;
  logic       ch_ok, io_ok;
  logic       is_mode, is_clk, is_commit, is_status, is_lock, is_buf, unmapped;
  logic [NUM_CHN-1:0] ch_hit;
  logic [NUM_IO-1:0]  io_hit;
  logic       lock_sel;
  logic       wr_acc, wr_err, wr_ok, rd_first, rd_err, commit_go;
  logic [31:0] rd_data;
  logic       unused_ok;

  logic [NUM_CHN-1:0][2:0]              mode_sh_q;
  logic [NUM_CHN-1:0][11:0]             clk_sh_q;
  logic [NUM_CHN-1:0][NUM_IO-1:0][26:0] buf_sh_q;
  logic [NUM_CHN-1:0][3:0]              status_q;
  logic [NUM_CHN-1:0]                   lock_q;

  state_t                               state_q;
  logic [7:0]                           cnt_q;
  logic [3:0]                           commit_ch_q;
  logic                                 busy_q;
  logic [NUM_CHN-1:0][2:0]              act_mode_q;
  logic [NUM_CHN-1:0][11:0]             act_clk_q;
  logic [NUM_CHN-1:0][NUM_IO-1:0][26:0] act_buf_q;
  logic [NUM_CHN-1:0]                   cfg_chg_q;

  logic        rd_phase_q, rd_err_q;
  logic [31:0] prdata_q;

  assign ch        = i_paddr[15:12];
  assign word      = i_paddr[11:2];
  assign io_idx    = word[7:0];
  assign ch_ok     = {28'd0, ch} < 32'(NUM_CHN);
  assign io_ok     = {24'd0, io_idx} < 32'(NUM_IO);
  assign is_mode   = word == 10'h000;
  assign is_clk    = word == 10'h001;
  assign is_commit = word == 10'h002;
  assign is_status = word == 10'h003;
  assign is_lock   = word == 10'h004;
  assign is_buf    = word[9:8] == 2'b01;
  assign unmapped  = !(is_mode | is_clk | is_commit | is_status | is_lock | is_buf);
  assign unused_ok = &{1'b0, i_pwdata[31:27], i_paddr[1:0]};

  always_comb begin
    ch_hit = '0;
    io_hit = '0;
    for (int c = 0; c < NUM_CHN; c++) ch_hit[c] = {28'd0, ch} == 32'(c);
    for (int i = 0; i < NUM_IO; i++) io_hit[i] = {24'd0, io_idx} == 32'(i);
  end

  assign lock_sel = |(lock_q & ch_hit);

  // APB handshake: an access is any cycle with psel&penable and it ends in the cycle
  // o_pready is high; writes end in their first access cycle, reads hold o_pready low for
  // exactly one cycle and finish with registered o_prdata/o_pslverr. Idle bus: pready=1.
  assign wr_acc    = i_psel & i_penable & i_pwrite;
  assign wr_err    = !ch_ok | unmapped | (is_buf & !io_ok)
                   | ((is_mode | is_clk | is_buf) & lock_sel) | (is_commit & busy_q);
  assign wr_ok     = wr_acc & !wr_err;
  assign rd_first  = i_psel & i_penable & !i_pwrite & !rd_phase_q;
  assign rd_err    = !ch_ok | unmapped | (is_buf & !io_ok) | is_commit;
  assign commit_go = wr_ok & is_commit;

  assign o_pready  = !rd_first;
  assign o_pslverr = (wr_acc & wr_err) | (rd_phase_q & i_psel & i_penable & !i_pwrite & rd_err_q);
  assign o_prdata  = prdata_q;

  always_comb begin
    rd_data = '0;
    for (int c = 0; c < NUM_CHN; c++) begin
      if (ch_hit[c]) begin
        if (is_mode)        rd_data = {29'd0, mode_sh_q[c]};
        else if (is_clk)    rd_data = {20'd0, clk_sh_q[c]};
        else if (is_status) rd_data = {28'd0, status_q[c]};
        else if (is_lock)   rd_data = {31'd0, lock_q[c]};
        else if (is_buf) begin
          for (int i = 0; i < NUM_IO; i++)
            if (io_hit[i]) rd_data = {5'd0, buf_sh_q[c][i]};
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_phase_q <= 1'b0;
      rd_err_q   <= 1'b0;
      prdata_q   <= '0;
    end else begin
      rd_phase_q <= rd_first;
      if (rd_first) begin
        rd_err_q <= rd_err;
        prdata_q <= rd_err ? 32'd0 : rd_data;
      end
    end
  end

  // Shadow registers stay writable while a commit is running.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int c = 0; c < NUM_CHN; c++) begin
        mode_sh_q[c] <= MODE_RST;
        clk_sh_q[c]  <= CLK_RST;
        for (int i = 0; i < NUM_IO; i++) buf_sh_q[c][i] <= BUF_RST;
      end
    end else if (wr_ok) begin
      for (int c = 0; c < NUM_CHN; c++) begin
        if (ch_hit[c]) begin
          if (is_mode) mode_sh_q[c] <= i_pwdata[2:0];
          if (is_clk)  clk_sh_q[c]  <= i_pwdata[11:0];
          for (int i = 0; i < NUM_IO; i++)
            if (is_buf && io_hit[i]) buf_sh_q[c][i] <= i_pwdata[26:0];
        end
      end
    end
  end

  // A new event wins over a same-cycle W1C of the same bit.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      status_q <= '0;
      lock_q   <= '0;
    end else begin
      for (int c = 0; c < NUM_CHN; c++) begin
        if (wr_ok && is_status && ch_hit[c])
          status_q[c] <= (status_q[c] & ~i_pwdata[3:0]) | i_evt[c];
        else
          status_q[c] <= status_q[c] | i_evt[c];
        if (wr_ok && is_lock && ch_hit[c] && i_pwdata[0]) lock_q[c] <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      commit_ch_q <= '0;
      busy_q      <= 1'b0;
      cfg_chg_q   <= '0;
      for (int c = 0; c < NUM_CHN; c++) begin
        act_mode_q[c] <= MODE_RST;
        act_clk_q[c]  <= CLK_RST;
        for (int i = 0; i < NUM_IO; i++) act_buf_q[c][i] <= BUF_RST;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (commit_go) begin
            state_q     <= S_COPY;
            busy_q      <= 1'b1;
            commit_ch_q <= ch;
          end
        end
        S_COPY: begin
          for (int c = 0; c < NUM_CHN; c++) begin
            if ({28'd0, commit_ch_q} == 32'(c)) begin
              act_mode_q[c] <= mode_sh_q[c];
              act_clk_q[c]  <= clk_sh_q[c];
              act_buf_q[c]  <= buf_sh_q[c];
            end
          end
          cnt_q   <= CHG_DLY;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          // WAIT lasts CHG_DLY cycles, giving CHG_DLY+2 cycles from commit write to toggle.
          cnt_q <= cnt_q - 8'd1;
          if (cnt_q <= 8'd1) state_q <= S_TOGGLE;
        end
        S_TOGGLE: begin
          for (int c = 0; c < NUM_CHN; c++)
            if ({28'd0, commit_ch_q} == 32'(c)) cfg_chg_q[c] <= !cfg_chg_q[c];
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_chn_mode   = act_mode_q;
  assign o_clkgen_cfg = act_clk_q;
  assign o_buf_cfg    = act_buf_q;
  assign o_cfg_chg    = cfg_chg_q;
  assign o_busy       = busy_q;
  assign o_dbg_state  = state_q;

endmodule

// File: tb/tb_aib_cfg_regfile_mc.sv
// Bench for aib_cfg_regfile_mc: directed scenarios then randomized APB and event traffic,
// checked against a cycle-count based behavioural model of the register file.
module tb_aib_cfg_regfile_mc;
  localparam int NCH = 4;
  localparam int NIO = 8;
  localparam int DLY = 4;
  localparam logic [26:0] BUF_RST = 27'h0B10000;

  logic i_clk, i_rst_n, i_psel, i_penable, i_pwrite;
  logic [15:0] i_paddr;
  logic [31:0] i_pwdata;
  logic [NCH-1:0][3:0] i_evt;
  logic o_pready, o_pslverr, o_busy;
  logic [31:0] o_prdata;
  logic [NCH-1:0][2:0] o_chn_mode;
  logic [NCH-1:0][11:0] o_clkgen_cfg;
  logic [NCH-1:0][NIO-1:0][26:0] o_buf_cfg;
  logic [NCH-1:0] o_cfg_chg;
  logic [1:0] o_dbg_state;

  aib_cfg_regfile_mc #(.NUM_CHN(NCH), .NUM_IO(NIO), .CHG_DLY(8'(DLY))) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_psel(i_psel), .i_penable(i_penable),
    .i_pwrite(i_pwrite), .i_paddr(i_paddr), .i_pwdata(i_pwdata), .o_pready(o_pready),
    .o_pslverr(o_pslverr), .o_prdata(o_prdata), .i_evt(i_evt), .o_chn_mode(o_chn_mode),
    .o_clkgen_cfg(o_clkgen_cfg), .o_buf_cfg(o_buf_cfg), .o_cfg_chg(o_cfg_chg),
    .o_busy(o_busy), .o_dbg_state(o_dbg_state)
  );

  // clock/reset
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;
  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  // reference model
  logic [2:0]  m_mode [NCH];
  logic [11:0] m_clk  [NCH];
  logic [26:0] m_buf  [NCH][NIO];
  logic [2:0]  a_mode [NCH];
  logic [11:0] a_clk  [NCH];
  logic [26:0] a_buf  [NCH][NIO];
  logic [3:0]  m_stat [NCH];
  logic        m_lock [NCH];
  logic        m_chg  [NCH];
  logic        p_valid, p_copied;
  int          p_e0, p_ch;
  logic [2:0]  p_mode;
  logic [11:0] p_clk;
  logic [26:0] p_buf [NIO];
  int checks = 0;
  int errors = 0;

  function automatic void model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_mode[c] = 3'b100; a_mode[c] = 3'b100;
      m_clk[c] = 12'hCFF; a_clk[c] = 12'hCFF;
      for (int i = 0; i < NIO; i++) begin m_buf[c][i] = BUF_RST; a_buf[c][i] = BUF_RST; end
      m_stat[c] = 4'd0; m_lock[c] = 1'b0; m_chg[c] = 1'b0;
    end
    p_valid = 1'b0; p_copied = 1'b0;
  endfunction

  // A commit accepted at edge E0 copies at edge E0+1 and toggles at edge E0+DLY+2.
  function automatic void sync();
    if (p_valid && !p_copied && cyc >= p_e0 + 1) begin
      a_mode[p_ch] = p_mode; a_clk[p_ch] = p_clk;
      for (int i = 0; i < NIO; i++) a_buf[p_ch][i] = p_buf[i];
      p_copied = 1'b1;
    end
    if (p_valid && cyc >= p_e0 + DLY + 2) begin
      m_chg[p_ch] = !m_chg[p_ch];
      p_valid = 1'b0;
    end
  endfunction

  function automatic logic model_wr_err(input logic [15:0] a);
    int ch, w;
    ch = int'(a[15:12]); w = int'(a[11:2]);
    if (ch >= NCH) return 1'b1;
    if (w == 0 || w == 1) return m_lock[ch];
    if (w == 2) return p_valid;
    if (w == 3 || w == 4) return 1'b0;
    if (w >= 256 && w < 256 + NIO) return m_lock[ch];
    return 1'b1;
  endfunction

  function automatic void model_wr(input logic [15:0] a, input logic [31:0] d);
    int ch, w;
    ch = int'(a[15:12]); w = int'(a[11:2]);
    if (w == 0) m_mode[ch] = d[2:0];
    else if (w == 1) m_clk[ch] = d[11:0];
    else if (w == 2) begin
      p_valid = 1'b1; p_copied = 1'b0; p_e0 = cyc; p_ch = ch;
      p_mode = m_mode[ch]; p_clk = m_clk[ch];
      for (int i = 0; i < NIO; i++) p_buf[i] = m_buf[ch][i];
    end
    else if (w == 3) m_stat[ch] = m_stat[ch] & ~d[3:0];
    else if (w == 4) begin if (d[0]) m_lock[ch] = 1'b1; end
    else m_buf[ch][w-256] = d[26:0];
  endfunction

  function automatic logic [31:0] model_rd(input logic [15:0] a, output logic err);
    int ch, w;
    logic [31:0] r;
    ch = int'(a[15:12]); w = int'(a[11:2]);
    err = 1'b0; r = '0;
    if (ch >= NCH) err = 1'b1;
    else if (w == 0) r = {29'd0, m_mode[ch]};
    else if (w == 1) r = {20'd0, m_clk[ch]};
    else if (w == 3) r = {28'd0, m_stat[ch]};
    else if (w == 4) r = {31'd0, m_lock[ch]};
    else if (w >= 256 && w < 256 + NIO) r = {5'd0, m_buf[ch][w-256]};
    else err = 1'b1;
    return err ? 32'd0 : r;
  endfunction

  // scoreboard check
  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_outs(input string tag);
    logic [NIO*27-1:0] v;
    sync();
    chk({tag, ".busy"}, 256'(o_busy), 256'(p_valid));
    for (int c = 0; c < NCH; c++) begin
      for (int i = 0; i < NIO; i++) v[i*27 +: 27] = a_buf[c][i];
      chk($sformatf("%s.mode%0d", tag, c), 256'(o_chn_mode[c]), 256'(a_mode[c]));
      chk($sformatf("%s.clk%0d", tag, c), 256'(o_clkgen_cfg[c]), 256'(a_clk[c]));
      chk($sformatf("%s.chg%0d", tag, c), 256'(o_cfg_chg[c]), 256'(m_chg[c]));
      chk($sformatf("%s.buf%0d", tag, c), 256'(o_buf_cfg[c]), 256'(v));
    end
  endtask

  // driver tasks
  task automatic apb_wr(input logic [15:0] a, input logic [31:0] d, input logic [NCH-1:0][3:0] e,
                        input string tag, output logic got_err);
    logic exp_err;
    @(negedge i_clk);
    i_psel = 1'b1; i_pwrite = 1'b1; i_penable = 1'b0; i_paddr = a; i_pwdata = d;
    @(negedge i_clk);
    i_penable = 1'b1; i_evt = e;
    #1;
    sync();
    exp_err = model_wr_err(a);
    got_err = o_pslverr;
    chk({tag, ".wrdy"}, 256'(o_pready), 256'(1'b1));
    chk({tag, ".werr"}, 256'(o_pslverr), 256'(exp_err));
    @(posedge i_clk); #1;
    i_psel = 1'b0; i_penable = 1'b0; i_pwrite = 1'b0; i_evt = '0;
    sync();
    if (!exp_err) model_wr(a, d);
    for (int c = 0; c < NCH; c++) m_stat[c] = m_stat[c] | e[c];
  endtask

  task automatic apb_rd(input logic [15:0] a, input string tag);
    logic exp_err;
    logic [31:0] exp_d;
    @(negedge i_clk);
    i_psel = 1'b1; i_pwrite = 1'b0; i_penable = 1'b0; i_paddr = a;
    @(negedge i_clk);
    i_penable = 1'b1;
    #1;
    sync();
    exp_d = model_rd(a, exp_err);
    chk({tag, ".wait"}, 256'(o_pready), 256'(1'b0));
    @(negedge i_clk); #1;
    chk({tag, ".rrdy"}, 256'(o_pready), 256'(1'b1));
    chk({tag, ".rerr"}, 256'(o_pslverr), 256'(exp_err));
    chk({tag, ".rdat"}, 256'(o_prdata), 256'(exp_d));
    @(posedge i_clk); #1;
    i_psel = 1'b0; i_penable = 1'b0;
  endtask

  task automatic idle(input int n, input logic [NCH-1:0][3:0] e);
    for (int k = 0; k < n; k++) begin
      @(negedge i_clk);
      i_evt = e;
      #1;
      chk("idle.rdy", 256'(o_pready), 256'(1'b1));
      chk("idle.err", 256'(o_pslverr), 256'(1'b0));
      @(posedge i_clk); #1;
      i_evt = '0;
      for (int c = 0; c < NCH; c++) m_stat[c] = m_stat[c] | e[c];
    end
  endtask

  initial begin
    logic ge;
    logic [NCH-1:0][3:0] e;
    logic [3:0] cb;
    logic [9:0] wb;
    logic [31:0] d;
    int ch, w, kind, e0;

    i_rst_n = 1'b0; i_psel = 1'b0; i_penable = 1'b0; i_pwrite = 1'b0;
    i_paddr = '0; i_pwdata = '0; i_evt = '0;
    model_reset();
    repeat (3) @(posedge i_clk);
    #1;
    check_outs("rst");
    chk("rst.rdy", 256'(o_pready), 256'(1'b1));
    chk("rst.err", 256'(o_pslverr), 256'(1'b0));
    chk("rst.prdata", 256'(o_prdata), 256'(0));
    @(negedge i_clk);
    i_rst_n = 1'b1;

    // shadow write has no effect on active outputs until commit
    apb_wr(16'h1004, 32'h123, '0, "r31.wr", ge);
    apb_rd(16'h1004, "r31.rd");
    chk("r31.val", 256'(o_prdata), 256'(32'h123));
    check_outs("r31");
    chk("r31.act", 256'(o_clkgen_cfg[1]), 256'(12'hCFF));

    // commit ch1: copy one cycle after, toggle DLY+2 cycles after
    apb_wr(16'h1008, 32'h0, '0, "r32.commit", ge);
    e0 = cyc;
    while (cyc < e0 + 8) begin
      @(posedge i_clk); #1;
      check_outs("r32");
      if (cyc == e0 + 1) chk("r32.copied", 256'(o_clkgen_cfg[1]), 256'(12'h123));
      if (cyc >= e0 + 1 && cyc <= e0 + 3) chk("r32.busy", 256'(o_busy), 256'(1'b1));
      if (cyc == e0 + 5) chk("r32.pretog", 256'(o_cfg_chg[1]), 256'(1'b0));
      if (cyc == e0 + 6) chk("r32.tog", 256'(o_cfg_chg[1]), 256'(1'b1));
    end

    // commit while busy is rejected; bad channel is rejected
    apb_wr(16'h1008, 32'h0, '0, "r33.c1", ge);
    apb_wr(16'h2008, 32'h0, '0, "r33.c2", ge);
    chk("r33.busyerr", 256'(ge), 256'(1'b1));
    idle(10, '0);
    check_outs("r33");
    chk("r33.chg1", 256'(o_cfg_chg[1]), 256'(1'b0));
    chk("r33.chg2", 256'(o_cfg_chg[2]), 256'(1'b0));
    apb_wr(16'h4004, 32'h5, '0, "r33.ch4", ge);
    chk("r33.ch4err", 256'(ge), 256'(1'b1));

    // sticky status with W1C racing a new event
    e = '0; e[0] = 4'b0010;
    idle(1, e);
    apb_rd(16'h000C, "r34.st1");
    chk("r34.set", 256'(o_prdata), 256'(32'h2));
    apb_wr(16'h000C, 32'h2, e, "r34.race", ge);
    apb_rd(16'h000C, "r34.st2");
    chk("r34.race", 256'(o_prdata), 256'(32'h2));
    apb_wr(16'h000C, 32'h2, '0, "r34.clr", ge);
    apb_rd(16'h000C, "r34.st3");
    chk("r34.clr", 256'(o_prdata), 256'(32'h0));

    // lock blocks shadow writes; writing 0 to lock is silently ignored
    apb_wr(16'h0010, 32'h1, '0, "r35.lock", ge);
    apb_wr(16'h0400, 32'h1234567, '0, "r35.bufwr", ge);
    chk("r35.lockerr", 256'(ge), 256'(1'b1));
    apb_rd(16'h0400, "r35.bufrd");
    chk("r35.bufval", 256'(o_prdata), 256'(32'h0B10000));
    apb_wr(16'h0010, 32'h0, '0, "r35.unlock", ge);
    chk("r35.unlockerr", 256'(ge), 256'(1'b0));
    apb_rd(16'h0010, "r35.lockrd");
    chk("r35.lockval", 256'(o_prdata), 256'(32'h1));

    // randomized traffic
    for (int n = 0; n < 300; n++) begin
      ch = $urandom_range(0, NCH + 1);
      kind = $urandom_range(0, 10);
      case (kind)
        0: w = 0;
        1: w = 1;
        2: w = 2;
        3: w = 3;
        4: w = 4;
        5: w = 5 + $urandom_range(0, 250);
        6, 7, 8: w = 256 + $urandom_range(0, NIO - 1);
        9: w = 256 + $urandom_range(NIO, 255);
        default: w = 512 + $urandom_range(0, 500);
      endcase
      cb = 4'(ch); wb = 10'(w);
      d = $urandom();
      if (w == 4) d[0] = ($urandom_range(0, 7) == 0);
      e = ($urandom_range(0, 3) == 0) ? (NCH*4)'($urandom()) : '0;
      if ($urandom_range(0, 1) == 0) apb_wr({cb, wb, 2'b00}, d, e, "rnd.wr", ge);
      else apb_rd({cb, wb, 2'b00}, "rnd.rd");
      if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 4), '0);
      if (n % 10 == 0) check_outs("rnd");
    end

    // reset in the middle of a commit wait
    idle(DLY + 4, '0);
    apb_wr(16'h2008, 32'h0, '0, "rst2.commit", ge);
    e0 = cyc;
    while (cyc < e0 + 3) begin @(posedge i_clk); #1; end
    chk("rst2.busy", 256'(o_busy), 256'(1'b1));
    @(negedge i_clk); #2;
    i_rst_n = 1'b0;
    #1;
    model_reset();
    check_outs("rst2");
    chk("rst2.idle", 256'(o_busy), 256'(1'b0));
    chk("rst2.rdy", 256'(o_pready), 256'(1'b1));
    chk("rst2.err", 256'(o_pslverr), 256'(1'b0));
    chk("rst2.prdata", 256'(o_prdata), 256'(0));
    @(negedge i_clk);
    i_rst_n = 1'b1;
    apb_rd(16'h2004, "rst2.clkrd");
    chk("rst2.clkval", 256'(o_prdata), 256'(32'hCFF));
    idle(DLY + 4, '0);
    check_outs("rst2.after");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
